// File: rtl/heap_pkg.sv
// Shared types and defaults for the heap initiator.
// Holds the FSM state encoding, the op encoding and the default sizes.
package heap_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESULT    = 3'd4
    } state_e;

    // The op encoding matches heap_rnw, so the op register drives it directly.
    typedef enum logic {
        OP_PUSH = 1'b0,
        OP_POP  = 1'b1
    } op_e;

    localparam int DATA_WD_DEF      = 16;
    localparam int CAPACITY_DEF     = 8;
    localparam int BUSY_TIMEOUT_DEF = 4;

endpackage

// File: rtl/heap_master.sv
// Initiator for the min-heap: one command in flight, single-cycle cs, result pulse on pop.
// Occupancy is tracked locally so the heap is never overfilled or popped while empty.
module heap_master
    import heap_pkg::*;
#(
    parameter int data_wd      = DATA_WD_DEF,
    parameter int capacity     = CAPACITY_DEF,
    parameter int busy_timeout = BUSY_TIMEOUT_DEF
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        push_valid_i,
    input  logic [data_wd-1:0]          push_data_i,
    output logic                        push_ready_o,
    input  logic                        pop_valid_i,
    output logic                        pop_ready_o,
    output logic                        res_valid_o,
    output logic [data_wd-1:0]          res_data_o,
    output logic [$clog2(capacity)-1:0] count_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic                        err_o,
    output logic                        heap_cs_o,
    output logic                        heap_rnw_o,
    output logic [data_wd-1:0]          heap_wr_data_o,
    input  logic [data_wd-1:0]          heap_rd_data_i,
    input  logic                        heap_valid_i,
    input  logic                        heap_ready_i
);

    localparam int CNT_W = $clog2(capacity);
    localparam int TMR_W = $clog2(busy_timeout + 1);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [data_wd-1:0] data_q, data_d;
    logic [data_wd-1:0] res_data_q, res_data_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               err_q, err_d;
    logic               full, empty;

    assign full  = (count_q == CNT_W'(capacity - 1));
    assign empty = (count_q == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            op_q       <= OP_POP;
            data_q     <= '0;
            res_data_q <= '0;
            count_q    <= '0;
            tmr_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            data_q     <= data_d;
            res_data_q <= res_data_d;
            count_q    <= count_d;
            tmr_q      <= tmr_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        data_d       = data_q;
        res_data_d   = res_data_q;
        count_d      = count_q;
        tmr_d        = tmr_q;
        err_d        = err_q;
        push_ready_o = 1'b0;
        pop_ready_o  = 1'b0;

        case (state_q)
            IDLE: begin
                // A pending pop blocks pushes unless the heap is empty.
                pop_ready_o  = !rst_i && heap_ready_i && !empty;
                push_ready_o = !rst_i && heap_ready_i && !full && !(pop_valid_i && !empty);
                if (pop_valid_i && pop_ready_o) begin
                    op_d    = OP_POP;
                    state_d = ISSUE;
                end else if (push_valid_i && push_ready_o) begin
                    op_d    = OP_PUSH;
                    data_d  = push_data_i;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                count_d = (op_q == OP_POP) ? count_q - CNT_W'(1) : count_q + CNT_W'(1);
                tmr_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A heap that never drops ready is flagged; count stays as issued.
                if (!heap_ready_i) begin
                    state_d = WAIT_DONE;
                end else if (tmr_q == TMR_W'(busy_timeout - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            WAIT_DONE: begin
                if (heap_ready_i) begin
                    if (op_q == OP_POP) begin
                        res_data_d = heap_rd_data_i;
                        if (!heap_valid_i) begin
                            err_d = 1'b1;
                        end
                        state_d = RESULT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            RESULT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign heap_cs_o      = (state_q == ISSUE);
    assign heap_rnw_o     = (state_q == ISSUE) ? op_q : 1'b1;
    assign heap_wr_data_o = (state_q == ISSUE && op_q == OP_PUSH) ? data_q : '0;
    assign res_valid_o    = (state_q == RESULT);
    assign res_data_o     = res_data_q;
    assign count_o        = count_q;
    assign full_o         = full;
    assign empty_o        = empty;
    assign err_o          = err_q;

endmodule

// File: tb/tb_heap_master.sv
// Bench for heap_master: behavioural min-heap responder plus a queue-based reference model.
module tb_heap_master;
    import heap_pkg::*;

    localparam int DW   = 16;
    localparam int CAP  = 8;
    localparam int HLAT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          push_valid, push_ready, pop_valid, pop_ready;
    logic [DW-1:0] push_data, res_data;
    logic          res_valid, full, empty, err;
    logic [2:0]    count;
    logic          h_cs, h_rnw, h_valid, h_ready;
    logic [DW-1:0] h_wr, h_rd;

    int n_chk  = 0;
    int n_fail = 0;
    int unsigned ref_q[$];
    bit stuck;

    always #5 clk = ~clk;

    heap_master #(.data_wd(DW), .capacity(CAP), .busy_timeout(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .push_valid_i(push_valid), .push_data_i(push_data), .push_ready_o(push_ready),
        .pop_valid_i(pop_valid), .pop_ready_o(pop_ready),
        .res_valid_o(res_valid), .res_data_o(res_data),
        .count_o(count), .full_o(full), .empty_o(empty), .err_o(err),
        .heap_cs_o(h_cs), .heap_rnw_o(h_rnw), .heap_wr_data_o(h_wr),
        .heap_rd_data_i(h_rd), .heap_valid_i(h_valid), .heap_ready_i(h_ready)
    );

    // Min-heap stand-in: sorted packed array, busy (ready low) for HLAT cycles per command.
    logic [CAP-1:0][DW-1:0] hm_q;
    int hm_n, hm_cnt;

    function automatic logic [CAP-1:0][DW-1:0] ins(input logic [CAP-1:0][DW-1:0] a,
                                                   input int n, input logic [DW-1:0] d);
        logic [CAP-1:0][DW-1:0] r;
        int p;
        r = a;
        p = n;
        for (int i = 0; i < CAP; i++) if (i < n && a[i] > d && p == n) p = i;
        for (int i = CAP-1; i > 0; i--) if (i > p) r[i] = a[i-1];
        if (p < CAP) r[p] = d;
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            hm_q <= '0; hm_n <= 0; hm_cnt <= 0;
            h_ready <= 1'b1; h_valid <= 1'b0; h_rd <= '0;
        end else if (h_cs && !stuck) begin
            h_ready <= 1'b0;
            hm_cnt  <= HLAT - 1;
            if (h_rnw) begin
                h_rd    <= hm_q[0];
                h_valid <= (hm_n > 0);
                hm_q    <= hm_q >> DW;
                hm_n    <= (hm_n > 0) ? hm_n - 1 : 0;
            end else begin
                hm_q <= ins(hm_q, hm_n, h_wr);
                hm_n <= hm_n + 1;
            end
        end else if (!h_ready) begin
            if (hm_cnt == 0) h_ready <= 1'b1;
            else hm_cnt <= hm_cnt - 1;
        end
    end

    function automatic int unsigned ref_pop();
        int mi;
        int unsigned v;
        mi = 0;
        for (int i = 1; i < ref_q.size(); i++) if (ref_q[i] < ref_q[mi]) mi = i;
        v = ref_q[mi];
        ref_q.delete(mi);
        return v;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_flags();
        chk("count_vs_model", count, ref_q.size());
        chk("full_vs_model", full, ref_q.size() == CAP-1);
        chk("empty_vs_model", empty, ref_q.size() == 0);
    endtask

    // Called and returns at a negedge.
    task automatic do_push(input logic [DW-1:0] d);
        bit ok;
        int c0;
        ok = 0;
        c0 = ref_q.size();
        push_valid = 1'b1; push_data = d;
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            if (push_ready) ok = 1; else @(negedge clk);
        end
        chk("push_accept", ok, 1);
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
            push_valid = 1'b0;
            ref_q.push_back(d);
            chk("push_cs", h_cs, 1);
            chk("push_rnw", h_rnw, 0);
            chk("push_wdata", h_wr, d);
            chk("push_cnt_hold", count, c0);
            @(negedge clk);
            chk("push_cs_drop", h_cs, 0);
            chk("push_cnt_inc", count, c0 + 1);
            repeat (HLAT + 1) @(negedge clk);
        end else begin
            @(negedge clk);
            push_valid = 1'b0;
        end
    endtask

    task automatic do_pop(output logic [DW-1:0] got);
        bit ok, seen;
        int lat;
        ok = 0; seen = 0; lat = 0; got = '0;
        pop_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            if (pop_ready) ok = 1; else @(negedge clk);
        end
        chk("pop_accept", ok, 1);
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
            pop_valid = 1'b0;
            lat = 1;
            chk("pop_cs", h_cs, 1);
            chk("pop_rnw", h_rnw, 1);
            for (int i = 0; i < 20 && !seen; i++) begin
                if (res_valid) begin seen = 1; got = res_data; end
                else begin @(negedge clk); lat++; end
            end
            chk("pop_res_seen", seen, 1);
            chk("pop_latency", lat, 6);
            chk("pop_data_vs_model", got, ref_pop());
            @(negedge clk);
            chk("res_pulse_one_cycle", res_valid, 0);
            chk("res_data_held", res_data, got);
        end else begin
            @(negedge clk);
            pop_valid = 1'b0;
        end
    endtask

    typedef struct {
        bit            is_pop;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_res;
        int            exp_cnt;
    } vec_t;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        logic [DW-1:0] got;
        bit saw_rdy, saw_cs, ok, seen;

        tbl[0] = '{0, 16'd5, 16'd0, 1};
        tbl[1] = '{0, 16'd3, 16'd0, 2};
        tbl[2] = '{0, 16'd9, 16'd0, 3};
        tbl[3] = '{1, 16'd0, 16'd3, 2};
        tbl[4] = '{1, 16'd0, 16'd5, 1};
        tbl[5] = '{1, 16'd0, 16'd9, 0};

        rst = 1'b1; stuck = 0;
        push_valid = 0; push_data = '0; pop_valid = 0;
        repeat (3) @(negedge clk);
        chk("rst_cs", h_cs, 0);
        chk("rst_rnw", h_rnw, 1);
        chk("rst_wdata", h_wr, 0);
        chk("rst_push_ready", push_ready, 0);
        chk("rst_pop_ready", pop_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);

        // Three pushes then three pops.
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].is_pop) begin
                do_pop(got);
                chk("tbl_res", got, tbl[i].exp_res);
            end else begin
                do_push(tbl[i].d);
            end
            chk("tbl_count", count, tbl[i].exp_cnt);
        end
        chk("tbl_empty", empty, 1);

        // Pop request while empty is never accepted.
        saw_rdy = 0; saw_cs = 0;
        pop_valid = 1'b1;
        repeat (6) begin
            #1;
            if (pop_ready) saw_rdy = 1;
            if (h_cs) saw_cs = 1;
            @(negedge clk);
        end
        pop_valid = 1'b0;
        chk("empty_pop_ready", saw_rdy, 0);
        chk("empty_pop_cs", saw_cs, 0);
        chk("empty_pop_err", err, 0);

        // Fill to capacity-1, then hold an extra push.
        for (int i = 0; i < CAP-1; i++) do_push(DW'($urandom_range(0, 1000)));
        chk("fill_full", full, 1);
        saw_rdy = 0; saw_cs = 0;
        push_valid = 1'b1; push_data = 16'd1234;
        repeat (6) begin
            #1;
            if (push_ready) saw_rdy = 1;
            if (h_cs) saw_cs = 1;
            @(negedge clk);
        end
        push_valid = 1'b0;
        chk("fill_push_ready", saw_rdy, 0);
        chk("fill_no_cs", saw_cs, 0);
        chk("fill_count", count, CAP-1);
        for (int i = 0; i < CAP-1; i++) do_pop(got);
        chk("drain_empty", empty, 1);

        // Simultaneous push and pop: pop wins, push follows.
        do_push(16'd6);
        do_push(16'd4);
        push_valid = 1'b1; push_data = 16'd1; pop_valid = 1'b1;
        #1;
        chk("simul_push_ready", push_ready, 0);
        chk("simul_pop_ready", pop_ready, 1);
        @(posedge clk);
        @(negedge clk);
        pop_valid = 1'b0;
        chk("simul_cs_rnw", h_rnw, 1);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (res_valid) begin seen = 1; got = res_data; end
            else @(negedge clk);
        end
        chk("simul_res_seen", seen, 1);
        chk("simul_res_data", got, 4);
        void'(ref_pop());
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (push_ready) ok = 1;
        end
        chk("simul_push_later", ok, 1);
        @(posedge clk);
        @(negedge clk);
        push_valid = 1'b0;
        chk("simul_push_cs", h_cs, 1);
        chk("simul_push_wdata", h_wr, 1);
        ref_q.push_back(1);
        repeat (HLAT + 2) @(negedge clk);
        do_pop(got);
        chk("simul_next_min", got, 1);
        do_pop(got);
        chk("simul_last", got, 6);

        // Randomised traffic against the queue model.
        for (int k = 0; k < 40; k++) begin
            chk_flags();
            if ((($urandom_range(0, 1) == 1) && ref_q.size() > 0) || ref_q.size() == CAP-1)
                do_pop(got);
            else
                do_push(DW'($urandom));
        end
        while (ref_q.size() > 0) do_pop(got);
        chk_flags();

        // Stuck heap: ready never falls, err after the timeout.
        stuck = 1;
        push_valid = 1'b1; push_data = 16'd77;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (push_ready) ok = 1; else @(negedge clk);
        end
        chk("stuck_accept", ok, 1);
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            push_valid = 1'b0;
            if (k == 5) chk("stuck_err_early", err, 0);
        end
        chk("stuck_err", err, 1);
        chk("stuck_count_kept", count, 1);
        chk("stuck_back_idle", pop_ready, 1);
        stuck = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("stuck_rst_err", err, 0);
        chk("stuck_rst_count", count, 0);
        ref_q.delete();
        @(negedge clk);

        // Reset while a pop waits in WAIT_DONE.
        do_push(16'd42);
        pop_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (pop_ready) ok = 1; else @(negedge clk);
        end
        chk("rstpop_accept", ok, 1);
        @(posedge clk);
        @(negedge clk);
        pop_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstpop_cs", h_cs, 0);
        chk("rstpop_count", count, 0);
        ref_q.delete();
        seen = 0;
        repeat (10) begin
            if (res_valid) seen = 1;
            @(negedge clk);
        end
        chk("rstpop_no_result", seen, 0);
        do_push(16'd8);
        do_pop(got);
        chk("after_rst_pop", got, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
